// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP read sequencer: slot addresses, FSM
// encoding, status bit positions and grant encoding.
package xadc_pkg;

    localparam logic [6:0] ADDR_VAUX6  = 7'h16;
    localparam logic [6:0] ADDR_VAUX7  = 7'h17;
    localparam logic [6:0] ADDR_VAUX14 = 7'h1E;
    localparam logic [6:0] ADDR_VAUX15 = 7'h1F;

    localparam int ST_TIMEOUT = 0;
    localparam int ST_OVERRUN = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } drp_state_t;

    typedef enum logic {
        GNT_HOST = 1'b0,
        GNT_SCAN = 1'b1
    } grant_t;

    // Under contention the requester not served last wins.
    function automatic grant_t other_grant(input grant_t last);
        return (last == GNT_SCAN) ? GNT_HOST : GNT_SCAN;
    endfunction

endpackage

// File: rtl/period_tick.sv
// Free-running scan period counter: counts 0..PERIOD-1 while enabled and
// pulses tick for one cycle on wrap; disabling holds it at zero.
module period_tick #(
    parameter int unsigned PERIOD = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Read-only DRP master: periodically scans four aux-channel registers and
// shares the DRP port with a single host requester, alternating under contention.
module xadc_drp_sequencer
    import xadc_pkg::*;
#(
    parameter int unsigned PERIOD  = 1_000_000,
    parameter int unsigned TIMEOUT = 64,
    parameter logic [6:0]  CH0     = ADDR_VAUX6,
    parameter logic [6:0]  CH1     = ADDR_VAUX7,
    parameter logic [6:0]  CH2     = ADDR_VAUX14,
    parameter logic [6:0]  CH3     = ADDR_VAUX15
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic        en,
    output logic        drp_den,
    output logic [6:0]  drp_daddr,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic        host_req,
    input  logic [6:0]  host_addr,
    output logic        host_ack,
    output logic [15:0] host_data,
    output logic        host_err,
    output logic        smp_valid,
    output logic [1:0]  smp_ch,
    output logic [15:0] smp_data,
    output logic [1:0]  status
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    drp_state_t state, state_next;
    grant_t     last_grant, cur_grant, grant_sel;
    logic       grant;
    logic       timed_out;
    logic       tick;
    logic       scan_pend;
    logic [1:0] slot;
    logic [6:0] slot_addr;
    logic [TW-1:0] to_cnt;
    logic [15:0]   rd_data;

    period_tick #(.PERIOD(PERIOD)) u_period_tick (
        .clk  (CLK100MHZ),
        .rst  (RST),
        .en   (en),
        .tick (tick)
    );

    always_comb begin
        slot_addr = CH0;
        case (slot)
            2'd0:    slot_addr = CH0;
            2'd1:    slot_addr = CH1;
            2'd2:    slot_addr = CH2;
            default: slot_addr = CH3;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_sel  = last_grant;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (host_req && scan_pend) begin
                    grant     = 1'b1;
                    grant_sel = other_grant(last_grant);
                end else if (host_req) begin
                    grant     = 1'b1;
                    grant_sel = GNT_HOST;
                end else if (scan_pend) begin
                    grant     = 1'b1;
                    grant_sel = GNT_SCAN;
                end
                if (grant) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (drp_drdy) begin
                    state_next = DONE;
                end else if (to_cnt == TO_LAST) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_data = drp_drdy ? drp_do : 16'h0000;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            drp_den    <= 1'b0;
            drp_daddr  <= '0;
            host_ack   <= 1'b0;
            host_data  <= '0;
            host_err   <= 1'b0;
            smp_valid  <= 1'b0;
            smp_ch     <= '0;
            smp_data   <= '0;
            status     <= '0;
            last_grant <= GNT_SCAN;
            cur_grant  <= GNT_SCAN;
            slot       <= '0;
            scan_pend  <= 1'b0;
            to_cnt     <= '0;
        end else begin
            drp_den   <= 1'b0;
            host_ack  <= 1'b0;
            smp_valid <= 1'b0;

            // den is registered at the grant edge so it is high exactly in ISSUE
            if (grant) begin
                last_grant <= grant_sel;
                cur_grant  <= grant_sel;
                drp_daddr  <= (grant_sel == GNT_HOST) ? host_addr : slot_addr;
                drp_den    <= 1'b1;
            end

            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if (state == WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state == WAIT && state_next == DONE) begin
                if (cur_grant == GNT_HOST) begin
                    host_ack  <= 1'b1;
                    host_data <= rd_data;
                    host_err  <= timed_out;
                end else begin
                    smp_valid <= 1'b1;
                    smp_ch    <= slot;
                    smp_data  <= rd_data;
                end
                if (timed_out) begin
                    status[ST_TIMEOUT] <= 1'b1;
                end
            end

            if (state == DONE && cur_grant == GNT_SCAN) begin
                slot <= slot + 2'd1;
            end

            if (!en) begin
                scan_pend <= 1'b0;
            end else if (tick && !scan_pend) begin
                scan_pend <= 1'b1;
            end else if (state == DONE && cur_grant == GNT_SCAN && slot == 2'd3) begin
                scan_pend <= 1'b0;
            end

            if (tick && scan_pend) begin
                status[ST_OVERRUN] <= 1'b1;
            end
        end
    end

endmodule
